// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter:
// FSM state encoding, parity-mode selectors and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        X_IDLE   = 3'd0,
        X_START  = 3'd1,
        X_DATA   = 3'd2,
        X_PARITY = 3'd3,
        X_STOP   = 3'd4
    } xmit_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the transmitter; pointers carry an extra
// wrap bit so full and empty are told apart without a separate counter.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered pointers, so a same-cycle pop never frees room.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_xmit_cfg.sv
// Parametrised UART transmit engine: FIFO-fed frame FSM with exact OVS-cycle
// bit cells and a registered TX line that trails the FSM state by one cycle.
module uart_xmit_cfg #(
    parameter int DATA_W     = 8,
    parameter int OVS        = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_l,
    input  logic              xmitH,
    input  logic [DATA_W-1:0] xmit_dataH,
    output logic              xmit_fullH,
    output logic              xmit_ovfH,
    output logic              uart_xmitH,
    output logic              xmit_doneH,
    output logic              xmit_idleH,
    output logic [LW-1:0]     xmit_levelH
);
    import uart_pkg::*;

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CELL_LAST = CW'(OVS - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    xmit_state_t       state;
    xmit_state_t       next_state;
    logic [CW-1:0]     cell_cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              par_bit;
    logic              cell_last;
    logic              line_next;
    logic              pop;
    logic              frame_end;
    logic              done_d;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_l),
        .push  (xmitH),
        .wdata (xmit_dataH),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (xmit_fullH),
        .empty (fifo_empty),
        .level (xmit_levelH)
    );

    assign cell_last  = (cell_cnt == CELL_LAST);
    assign xmit_idleH = fifo_empty && (state == X_IDLE);

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        line_next  = HI;
        frame_end  = 1'b0;
        case (state)
            X_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = X_START;
                end
            end
            X_START: begin
                line_next = LO;
                if (cell_last) next_state = X_DATA;
            end
            X_DATA: begin
                line_next = shift[0];
                if (cell_last && bit_cnt == DATA_LAST)
                    next_state = (PARITY != PAR_NONE) ? X_PARITY : X_STOP;
            end
            X_PARITY: begin
                line_next = par_bit;
                if (cell_last) next_state = X_STOP;
            end
            X_STOP: begin
                if (cell_last && bit_cnt == STOP_LAST) begin
                    frame_end = 1'b1;
                    // Chain straight into the next start cell when a word is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = X_START;
                    end else begin
                        next_state = X_IDLE;
                    end
                end
            end
            default: next_state = X_IDLE;
        endcase
    end

    // done is delayed twice so it lands just after the last stop cell on the line.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= X_IDLE;
            cell_cnt   <= '0;
            bit_cnt    <= '0;
            uart_xmitH <= HI;
            done_d     <= 1'b0;
            xmit_doneH <= 1'b0;
            xmit_ovfH  <= 1'b0;
        end else begin
            state      <= next_state;
            uart_xmitH <= line_next;
            done_d     <= frame_end;
            xmit_doneH <= done_d;
            xmit_ovfH  <= xmitH && xmit_fullH;
            if (state == X_IDLE || cell_last) cell_cnt <= '0;
            else                              cell_cnt <= cell_cnt + 1'b1;
            if (next_state != state) bit_cnt <= '0;
            else if (cell_last)      bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            shift   <= '0;
            par_bit <= 1'b0;
        end else if (pop) begin
            shift   <= fifo_rdata;
            par_bit <= (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
        end else if (state == X_DATA && cell_last) begin
            shift <= shift >> 1;
        end
    end

endmodule
